verlet_node_array: RTL and testbench

- Time-multiplexed Verlet integrator holding NODES point masses in one register file, replacing per-node integrator instances.
- Each pass is started by a `start` pulse. One integration datapath sweeps all nodes, one node per cycle.
- Features: gravity, optional damping, per-node pinning, mouse impulse.
- The constraint solver upstream writes corrected positions back through a write port and reads state through a combinational read port.

---
 rtl/verlet_node_array.sv | 157 +++++++++++++++
 tb/tb_verlet_node_array.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/verlet_node_array.sv
// Time-multiplexed Verlet integrator: one datapath sweeps a register file of NODES point masses,
// one node per cycle, with gravity, optional damping, per-node pinning and a mouse impulse.
module verlet_node_array #(
    parameter int unsigned      NODES        = 8,
    parameter int unsigned      WIDTH        = 32,
    parameter int unsigned      FRAC         = 12,
    parameter logic [WIDTH-1:0] BASE_X       = 'h000C8000,
    parameter logic [WIDTH-1:0] SPACING      = 'h0000A000,
    parameter logic [255:0]     PIN_MASK     = 256'd1,
    parameter int unsigned      DAMP_SHIFT   = 0,
    parameter logic [WIDTH-1:0] MOUSE_RADIUS = 'h00002000,
    parameter logic [WIDTH-1:0] MOUSE_POWER  = 'h0000A000,
    localparam int unsigned     IDXW         = (NODES > 1) ? $clog2(NODES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] gravity,
    input  logic             mouse_en,
    input  logic [WIDTH-1:0] mouse_x,
    input  logic [WIDTH-1:0] mouse_y,
    input  logic             wr_en,
    input  logic [IDXW-1:0]  wr_idx,
    input  logic [WIDTH-1:0] wr_x,
    input  logic [WIDTH-1:0] wr_y,
    input  logic [IDXW-1:0]  rd_idx,
    output logic [WIDTH-1:0] rd_x,
    output logic [WIDTH-1:0] rd_y,
    output logic             busy,
    output logic             done
);

    if (NODES < 2 || NODES > 256 || FRAC >= WIDTH) begin : g_bad_params
        $error("verlet_node_array: unsupported parameter combination");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;

    logic [WIDTH-1:0] x_q  [NODES];
    logic [WIDTH-1:0] y_q  [NODES];
    logic [WIDTH-1:0] px_q [NODES];
    logic [WIDTH-1:0] py_q [NODES];

    logic [WIDTH-1:0]        cur_x, cur_y, cur_px, cur_py;
    logic [WIDTH-1:0]        vx_raw, vy_raw, vx, vy;
    logic signed [WIDTH-1:0] vx_sh, vy_sh;
    logic [WIDTH:0]          dx, dy, adx, ady;
    logic                    touch, mouse_left, pinned, wr_ok;
    logic [WIDTH-1:0]        nx, ny, npx, npy;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    idx_d   = '0;
                end
            end
            StRun: begin
                busy = 1'b1;
                if (32'(idx_q) == NODES - 1) begin
                    state_d = StDone;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cur_x  = x_q[idx_q];
        cur_y  = y_q[idx_q];
        cur_px = px_q[idx_q];
        cur_py = py_q[idx_q];
        pinned = PIN_MASK[idx_q];

        vx_raw = cur_x - cur_px;
        vy_raw = cur_y - cur_py;
        // Shift into signed temporaries so the shift stays arithmetic.
        vx_sh  = $signed(vx_raw) >>> DAMP_SHIFT;
        vy_sh  = $signed(vy_raw) >>> DAMP_SHIFT;
        vx     = vx_raw;
        vy     = vy_raw;
        if (DAMP_SHIFT > 0) begin
            vx = vx_raw - vx_sh;
            vy = vy_raw - vy_sh;
        end

        // One extra bit keeps the distance exact even for far-apart operands.
        dx  = {cur_x[WIDTH-1], cur_x} - {mouse_x[WIDTH-1], mouse_x};
        dy  = {cur_y[WIDTH-1], cur_y} - {mouse_y[WIDTH-1], mouse_y};
        adx = dx[WIDTH] ? -dx : dx;
        ady = dy[WIDTH] ? -dy : dy;
        touch = mouse_en && (adx <= {1'b0, MOUSE_RADIUS}) && (ady <= {1'b0, MOUSE_RADIUS});
        mouse_left = $signed(mouse_x) <= $signed(cur_x);

        nx  = cur_x + vx;
        ny  = cur_y + vy + gravity;
        npy = cur_y;
        npx = cur_x;
        if (touch) begin
            npx = mouse_left ? cur_x - MOUSE_POWER : cur_x + MOUSE_POWER;
        end

        wr_ok = 32'(wr_idx) < NODES;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            for (int i = 0; i < NODES; i++) begin
                x_q[i]  <= BASE_X;
                px_q[i] <= BASE_X;
                y_q[i]  <= WIDTH'(WIDTH'(i + 1) * SPACING);
                py_q[i] <= WIDTH'(WIDTH'(i + 1) * SPACING);
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (state_q == StRun && !pinned) begin
                x_q[idx_q]  <= nx;
                y_q[idx_q]  <= ny;
                px_q[idx_q] <= npx;
                py_q[idx_q] <= npy;
            end
            if (state_q == StIdle && wr_en && wr_ok) begin
                x_q[wr_idx] <= wr_x;
                y_q[wr_idx] <= wr_y;
            end
        end
    end

    always_comb begin
        rd_x = '0;
        rd_y = '0;
        if (32'(rd_idx) < NODES) begin
            rd_x = x_q[rd_idx];
            rd_y = y_q[rd_idx];
        end
    end

endmodule

// File: tb/tb_verlet_node_array.sv
// Bench for verlet_node_array: whole-pass behavioural model checked every cycle, plus literal
// expectations for the reference scenarios.
module tb_verlet_node_array;

    localparam int          NODES   = 4;
    localparam logic [31:0] BASE_X  = 32'h000C8000;
    localparam logic [31:0] SPACING = 32'h0000A000;
    localparam logic [31:0] RAD     = 32'h00002000;
    localparam logic [31:0] POW     = 32'h0000A000;
    localparam logic [3:0]  PIN     = 4'b0001;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, mouse_en = 1'b0, wr_en = 1'b0;
    logic [31:0] gravity = '0, mouse_x = '0, mouse_y = '0, wr_x = '0, wr_y = '0;
    logic [1:0]  wr_idx = '0, rd_idx = '0;
    logic [31:0] rd_x, rd_y, rd_x_d, rd_y_d;
    logic        busy, done, busy_d, done_d;

    int checks = 0;
    int errors = 0;

    logic [31:0] mx [NODES];
    logic [31:0] my [NODES];
    logic [31:0] mpx[NODES];
    logic [31:0] mpy[NODES];
    int          m_cnt   = 0;
    bit          m_valid = 1'b0;

    verlet_node_array #(.NODES(NODES), .WIDTH(32), .FRAC(12), .PIN_MASK(256'd1)) dut (
        .clk(clk), .reset(reset), .start(start), .gravity(gravity), .mouse_en(mouse_en),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x),
        .wr_y(wr_y), .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .busy(busy), .done(done)
    );

    verlet_node_array #(.NODES(NODES), .WIDTH(32), .FRAC(12), .PIN_MASK(256'd1),
                        .DAMP_SHIFT(2)) dut_d (
        .clk(clk), .reset(reset), .start(start), .gravity(gravity), .mouse_en(mouse_en),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x),
        .wr_y(wr_y), .rd_idx(rd_idx), .rd_x(rd_x_d), .rd_y(rd_y_d), .busy(busy_d),
        .done(done_d)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NODES; i++) begin
            mx[i]  = BASE_X;
            mpx[i] = BASE_X;
            my[i]  = 32'((i + 1) * SPACING);
            mpy[i] = my[i];
        end
    endtask

    // A whole pass at once: every node sees the inputs present when the pass was started.
    task automatic m_pass();
        logic [31:0] vx, vy;
        longint      dx, dy;
        bit          touch;
        for (int i = 0; i < NODES; i++) begin
            if (PIN[i]) continue;
            vx = mx[i] - mpx[i];
            vy = my[i] - mpy[i];
            dx = longint'($signed(mx[i])) - longint'($signed(mouse_x));
            dy = longint'($signed(my[i])) - longint'($signed(mouse_y));
            if (dx < 0) dx = -dx;
            if (dy < 0) dy = -dy;
            touch  = mouse_en && dx <= longint'(RAD) && dy <= longint'(RAD);
            mpy[i] = my[i];
            if (!touch) mpx[i] = mx[i];
            else if ($signed(mouse_x) <= $signed(mx[i])) mpx[i] = mx[i] - POW;
            else mpx[i] = mx[i] + POW;
            mx[i] = mx[i] + vx;
            my[i] = my[i] + vy + gravity;
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_reset();
            m_cnt   = 0;
            m_valid = 1'b1;
        end else if (m_cnt == 0) begin
            if (wr_en) begin
                mx[wr_idx] = wr_x;
                my[wr_idx] = wr_y;
            end
            if (start) begin
                m_pass();
                m_cnt = NODES + 1;
            end
        end else begin
            m_cnt--;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check32("busy", {31'b0, busy}, {31'b0, m_cnt > 0});
            check32("done", {31'b0, done}, {31'b0, m_cnt == 1});
            if (m_cnt == 0) begin
                check32("model_rd_x", rd_x, mx[rd_idx]);
                check32("model_rd_y", rd_y, my[rd_idx]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic run_pass();
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check32("done_latency", n, NODES + 1);
        tick();
    endtask

    task automatic expect_node(input int i, input logic [31:0] ex, input logic [31:0] ey,
                               input string tag);
        rd_idx = 2'(i);
        #1;
        check32({tag, "_x"}, rd_x, ex);
        check32({tag, "_y"}, rd_y, ey);
    endtask

    task automatic sweep_read();
        for (int i = 0; i < NODES; i++) begin
            rd_idx = 2'(i);
            tick();
        end
    endtask

    initial begin
        int ndone, ndone_d;
        tick();
        do_reset();

        // Reset contents.
        check32("reset_busy", {31'b0, busy}, 32'd0);
        check32("reset_done", {31'b0, done}, 32'd0);
        expect_node(0, 32'h000C8000, 32'h0000A000, "rst0");
        expect_node(1, 32'h000C8000, 32'h00014000, "rst1");
        expect_node(2, 32'h000C8000, 32'h0001E000, "rst2");
        expect_node(3, 32'h000C8000, 32'h00028000, "rst3");
        sweep_read();

        // Gravity, pinned node 0.
        gravity = 32'h400;
        run_pass();
        expect_node(1, 32'h000C8000, 32'h00014400, "grav1");
        expect_node(0, 32'h000C8000, 32'h0000A000, "pin0");
        run_pass();
        expect_node(1, 32'h000C8000, 32'h00014C00, "grav2");
        sweep_read();

        // Write committed in the same cycle as start feeds the pass.
        do_reset();
        gravity = '0;
        wr_en = 1'b1; wr_idx = 2'd2; wr_x = 32'h000D0000; wr_y = 32'h0001E000;
        run_pass();
        expect_node(2, 32'h000D8000, 32'h0001E000, "wr_start");
        rd_idx = 2'd2;
        #1;
        check32("damp_x", rd_x_d, 32'h000D6000);
        check32("damp_y", rd_y_d, 32'h0001E000);
        check32("damp_busy", {31'b0, busy_d}, 32'd0);
        sweep_read();

        // Mouse to the left of node 2: pushed toward +x.
        do_reset();
        mouse_en = 1'b1; mouse_x = 32'h000C7000; mouse_y = 32'h0001E000;
        run_pass();
        expect_node(2, 32'h000C8000, 32'h0001E000, "touch_l");
        mouse_en = 1'b0;
        run_pass();
        expect_node(2, 32'h000D2000, 32'h0001E000, "impulse_l");
        expect_node(3, 32'h000C8000, 32'h00028000, "untouched3");
        expect_node(1, 32'h000C8000, 32'h00014000, "untouched1");
        sweep_read();

        // Mouse to the right of node 3: pushed toward -x.
        do_reset();
        mouse_en = 1'b1; mouse_x = 32'h000C9000; mouse_y = 32'h00028000;
        run_pass();
        mouse_en = 1'b0;
        run_pass();
        expect_node(3, 32'h000BE000, 32'h00028000, "impulse_r");
        expect_node(2, 32'h000C8000, 32'h0001E000, "untouched2");
        sweep_read();

        // start and wr_en during a pass are dropped.
        do_reset();
        gravity = 32'h400;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; wr_en = 1'b1; wr_idx = 2'd3; wr_x = 32'h00012345; wr_y = 32'h00006789;
        tick();
        start = 1'b0; wr_en = 1'b0;
        ndone = 0; ndone_d = 0;
        for (int i = 0; i < 12; i++) begin
            ndone   += int'(done);
            ndone_d += int'(done_d);
            tick();
        end
        check32("single_done", ndone, 1);
        check32("single_done_d", ndone_d, 1);
        expect_node(3, 32'h000C8000, 32'h00028400, "busy_wr");

        // Reset during the pass aborts it.
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check32("abort_busy", {31'b0, busy}, 32'd0);
        check32("abort_done", {31'b0, done}, 32'd0);
        expect_node(1, 32'h000C8000, 32'h00014000, "abort1");
        expect_node(3, 32'h000C8000, 32'h00028000, "abort3");
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            ndone += int'(done);
            tick();
        end
        check32("abort_no_done", ndone, 0);
        sweep_read();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
